// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and constants for the ALU issue controller.
// Holds the FSM state encoding, instruction field positions, opcode values
// and a decode helper that splits a 16-bit word into its fields.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Instruction field bit positions
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RD_MSB      = 11;
  localparam int RD_LSB      = 10;
  localparam int RA_MSB      = 9;
  localparam int RA_LSB      = 8;
  localparam int RB_MSB      = 7;
  localparam int RB_LSB      = 6;
  localparam int USE_IMM_BIT = 5;
  localparam int IMM_MSB     = 4;
  localparam int IMM_LSB     = 0;

  // Opcodes, passed through to the external ALU untouched
  localparam logic [3:0] OP_ADD      = 4'h0;
  localparam logic [3:0] OP_ADD_BSHR = 4'h1;
  localparam logic [3:0] OP_AND      = 4'h2;
  localparam logic [3:0] OP_NOTB     = 4'h3;
  localparam logic [3:0] OP_XOR      = 4'h4;
  localparam logic [3:0] OP_EQ       = 4'h5;
  localparam logic [3:0] OP_XNOR     = 4'h6;
  localparam logic [3:0] OP_SHLB     = 4'h7;
  localparam logic [3:0] OP_XOR2     = 4'h8;
  localparam logic [3:0] OP_SUBBA    = 4'h9;
  localparam logic [3:0] OP_NOTA     = 4'hA;
  localparam logic [3:0] OP_OR       = 4'hB;
  localparam logic [3:0] OP_LT       = 4'hC;
  localparam logic [3:0] OP_PASSB    = 4'hD;
  localparam logic [3:0] OP_SHRA     = 4'hE;
  localparam logic [3:0] OP_GT       = 4'hF;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       use_imm;
    logic [4:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [15:0] w);
    instr_t d;
    d.op      = w[OP_MSB:OP_LSB];
    d.rd      = w[RD_MSB:RD_LSB];
    d.ra      = w[RA_MSB:RA_LSB];
    d.rb      = w[RB_MSB:RB_LSB];
    d.use_imm = w[USE_IMM_BIT];
    d.imm     = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// alu_issue_rf: 4 x 5-bit register file, two operand read ports, one write port,
// one debug read port. Reads are combinational; write lands on the rising edge.
// No backpressure; synchronous active-high reset clears all registers.
// Ports: clk, rst, we/wa/wd (write), ra_a/rd_a, ra_b/rd_b (operands), dbg_sel/dbg_data.
module alu_issue_rf
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [4:0] wd,
  input  logic [1:0] ra_a,
  output logic [4:0] rd_a,
  input  logic [1:0] ra_b,
  output logic [4:0] rd_b,
  input  logic [1:0] dbg_sel,
  output logic [4:0] dbg_data
);

  logic [4:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a     = regs[ra_a];
  assign rd_b     = regs[rb_idx_unused_guard(ra_b)];
  assign dbg_data = regs[dbg_sel];

  // Identity helper keeps the read-port index expression explicit.
  function automatic logic [1:0] rb_idx_unused_guard(input logic [1:0] idx);
    return idx;
  endfunction

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues 16-bit instructions to an external combinational ALU and
// writes the 5-bit result back to a 4-entry register file.
// Latency: accept, EXEC, RESP -> at least 3 cycles per instruction.
// Backpressure: instr_ready only in IDLE; result held in RESP until res_ready.
// Ports: clk, rst, instr_valid/instr_ready/instr (in), alu_s/alu_a/alu_b/alu_y (ALU),
//        res_valid/res_ready/res_data/res_rd/res_zero (out), dbg_sel/dbg_data, op_count.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_s,
  output logic [4:0]  alu_a,
  output logic [4:0]  alu_b,
  input  logic [4:0]  alu_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_data,
  output logic [1:0]  res_rd,
  output logic        res_zero,
  input  logic [1:0]  dbg_sel,
  output logic [4:0]  dbg_data,
  output logic [7:0]  op_count
);

  state_t     state;
  instr_t     d;
  logic [1:0] rd_q;
  logic [4:0] rf_a;
  logic [4:0] rf_b;
  logic       rf_we;

  assign d = decode_instr(instr);

  // The write happens during EXEC; operands were already latched at accept,
  // so an instruction whose rd matches ra/rb sees the pre-write values.
  assign rf_we = (state == ST_EXEC) && !rst;

  alu_issue_rf u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .wa       (rd_q),
    .wd       (alu_y),
    .ra_a     (d.ra),
    .rd_a     (rf_a),
    .ra_b     (d.rb),
    .rd_b     (rf_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      alu_s     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rd_q      <= '0;
      res_data  <= '0;
      res_rd    <= '0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            alu_s <= d.op;
            alu_a <= rf_a;
            alu_b <= d.use_imm ? d.imm : rf_b;
            rd_q  <= d.rd;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ALU output has settled for a full cycle on the operands latched at accept.
          res_data  <= alu_y;
          res_rd    <= rd_q;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == ST_IDLE);
  assign res_zero    = (res_data == 5'd0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl with a
// behavioural model of the external ALU.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_s;
  logic [4:0]  alu_a;
  logic [4:0]  alu_b;
  logic [4:0]  alu_y;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_data;
  logic [1:0]  res_rd;
  logic        res_zero;
  logic [1:0]  dbg_sel;
  logic [4:0]  dbg_data;
  logic [7:0]  op_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_s       (alu_s),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_y       (alu_y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_zero    (res_zero),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_model(input logic [3:0] s, input logic [4:0] a,
                                           input logic [4:0] b);
    logic [4:0] y;
    case (s)
      OP_ADD:      y = a + b;
      OP_ADD_BSHR: y = a + (b >> 1);
      OP_AND:      y = a & b;
      OP_NOTB:     y = ~b;
      OP_XOR:      y = a ^ b;
      OP_EQ:       y = {4'd0, a == b};
      OP_XNOR:     y = ~(a ^ b);
      OP_SHLB:     y = b << 1;
      OP_XOR2:     y = a ^ b;
      OP_SUBBA:    y = b - a;
      OP_NOTA:     y = ~a;
      OP_OR:       y = a | b;
      OP_LT:       y = {4'd0, a < b};
      OP_PASSB:    y = b;
      OP_SHRA:     y = a >> 1;
      default:     y = {4'd0, a > b};
    endcase
    return y;
  endfunction

  always_comb alu_y = alu_model(alu_s, alu_a, alu_b);

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb,
                                     input logic ui, input logic [4:0] imm);
    return {op, rd, ra, rb, ui, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string tag, input logic [1:0] idx, input logic [4:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, {27'd0, dbg_data}, {27'd0, exp});
  endtask

  // Present w in IDLE, let it be accepted, then wait for res_valid.
  // Returns positioned in the first RESP cycle.
  task automatic do_op(input logic [15:0] w);
    int lat;
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk("lat", lat, 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; res_ready = 1'b0; dbg_sel = '0;
    tick();
    tick();
    // Reset state
    chk("rst_ready", {31'd0, instr_ready}, 1);
    chk("rst_valid", {31'd0, res_valid}, 0);
    chk("rst_data", {27'd0, res_data}, 0);
    chk("rst_zero", {31'd0, res_zero}, 1);
    chk("rst_cnt", {24'd0, op_count}, 0);
    chk("rst_alu", {18'd0, alu_s, alu_a, alu_b}, 0);
    for (int i = 0; i < 4; i++) dbg_chk("rst_reg", i[1:0], 5'd0);
    rst = 1'b0;

    // ADD r1 = r0 + 5: check issued operands in EXEC, result in RESP
    instr = mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 5'd5);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("t1_s", {28'd0, alu_s}, 0);
    chk("t1_a", {27'd0, alu_a}, 0);
    chk("t1_b", {27'd0, alu_b}, 5);
    chk("t1_exec_valid", {31'd0, res_valid}, 0);
    chk("t1_exec_ready", {31'd0, instr_ready}, 0);
    tick();
    chk("t1_valid", {31'd0, res_valid}, 1);
    chk("t1_data", {27'd0, res_data}, 5);
    chk("t1_rd", {30'd0, res_rd}, 1);
    chk("t1_zero", {31'd0, res_zero}, 0);
    dbg_chk("t1_r1", 2'd1, 5'd5);
    handshake();
    chk("t1_cnt", {24'd0, op_count}, 1);
    chk("t1_idle", {31'd0, instr_ready}, 1);
    chk("t1_vlow", {31'd0, res_valid}, 0);
    chk("t1_hold_b", {27'd0, alu_b}, 5);

    // r1 = 31, then r2 = r1 + 1 wraps to 0
    do_op(mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 5'd31));
    chk("t2_r1", {27'd0, res_data}, 31);
    handshake();
    do_op(mk(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 5'd1));
    chk("t2_a", {27'd0, alu_a}, 31);
    chk("t2_data", {27'd0, res_data}, 0);
    chk("t2_zero", {31'd0, res_zero}, 1);
    chk("t2_rd", {30'd0, res_rd}, 2);
    handshake();
    dbg_chk("t2_r2", 2'd2, 5'd0);
    chk("t2_cnt", {24'd0, op_count}, 3);

    // Backpressure: PASSB r0 = 7 held five cycles in RESP
    do_op(mk(OP_PASSB, 2'd0, 2'd0, 2'd0, 1'b1, 5'd7));
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, res_valid}, 1);
      chk("bp_data", {27'd0, res_data}, 7);
      chk("bp_ready", {31'd0, instr_ready}, 0);
      chk("bp_cnt", {24'd0, op_count}, 3);
      tick();
    end
    handshake();
    chk("bp_cnt_after", {24'd0, op_count}, 4);
    dbg_chk("bp_r0", 2'd0, 5'd7);

    // Read-before-write: r3 = 6, then SUBBA r3 = r3 - r3
    do_op(mk(OP_PASSB, 2'd3, 2'd0, 2'd0, 1'b1, 5'd6));
    handshake();
    do_op(mk(OP_SUBBA, 2'd3, 2'd3, 2'd3, 1'b0, 5'd0));
    chk("rbw_s", {28'd0, alu_s}, 9);
    chk("rbw_a", {27'd0, alu_a}, 6);
    chk("rbw_b", {27'd0, alu_b}, 6);
    chk("rbw_data", {27'd0, res_data}, 0);
    handshake();
    dbg_chk("rbw_r3", 2'd3, 5'd0);

    // Opcode F passes through: GT r2 = (r0=7) > 3 -> 1
    do_op(mk(OP_GT, 2'd2, 2'd0, 2'd0, 1'b1, 5'd3));
    chk("gt_s", {28'd0, alu_s}, 15);
    chk("gt_data", {27'd0, res_data}, 1);
    handshake();
    chk("gt_cnt", {24'd0, op_count}, 7);

    // Reset during EXEC
    instr = mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 5'd1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rx_idle", {31'd0, instr_ready}, 1);
    chk("rx_valid", {31'd0, res_valid}, 0);
    chk("rx_cnt", {24'd0, op_count}, 0);
    dbg_chk("rx_r1", 2'd1, 5'd0);
    tick();
    chk("rx_valid2", {31'd0, res_valid}, 0);

    // Reset during RESP wins over a simultaneous handshake
    do_op(mk(OP_PASSB, 2'd0, 2'd0, 2'd0, 1'b1, 5'd9));
    res_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b0;
    chk("rr_cnt", {24'd0, op_count}, 0);
    chk("rr_valid", {31'd0, res_valid}, 0);
    dbg_chk("rr_r0", 2'd0, 5'd0);

    // 256 back-to-back r0 = r0 + 1, three cycles each, op_count wraps
    res_ready = 1'b1;
    instr = mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 5'd1);
    instr_valid = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      tick();
      chk("b2b_data", {27'd0, res_data}, k % 32);
      tick();
      if (k == 256) instr_valid = 1'b0;
      chk("b2b_cnt", {24'd0, op_count}, k % 256);
      chk("b2b_ready", {31'd0, instr_ready}, 1);
    end
    res_ready = 1'b0;
    dbg_chk("b2b_r0", 2'd0, 5'd0);
    tick();
    chk("b2b_stop", {31'd0, instr_ready}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
